rol_iter: RTL and testbench

- Iterative 16-bit rotate-left unit: the left-rotating counterpart of the combinational rotate-right block.
- Bits rotated off the left (MSB) end re-enter at the right (LSB) end.
- Performs one power-of-two rotate stage per clock (1, 2, 4, 8) under a valid/ready handshake on both input and output.
- Sits beside the datapath shifter for multi-cycle ROL ops; the output register is held until the consumer accepts it.

---
 rtl/rol_iter.sv | 107 ++++++++++
 tb/tb_rol_iter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rol_iter.sv
// Iterative rotate-left unit: one power-of-two rotate stage per clock (1, 2, 4, ...),
// with valid/ready handshakes on both operand input and result output.
module rol_iter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rol_in,
  input  logic [AMT_W-1:0] rol_val,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] rol_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned StW = (AMT_W > 1) ? $clog2(AMT_W) : 1;
  localparam logic [StW-1:0] LastStage = StW'(AMT_W - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [AMT_W-1:0] amt_q;
  logic [StW-1:0]   stage_q;
  logic             idle_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [WIDTH-1:0] rot;
  logic             accept;

  // Only the DONE -> SHIFT back-to-back case looks at out_ready combinationally.
  assign in_ready  = idle_q | (out_valid_q & out_ready);
  assign accept    = in_valid & in_ready;
  assign rol_out   = data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

  // Rotate data_q left by 2**stage_q.
  always_comb begin
    rot = data_q;
    for (int s = 0; s < int'(AMT_W); s++) begin
      if (stage_q == StW'(s)) begin
        rot = (data_q << (1 << s)) | (data_q >> (WIDTH - (1 << s)));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      data_q      <= '0;
      amt_q       <= '0;
      stage_q     <= '0;
      idle_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          idle_q <= 1'b1;
          if (accept) begin
            data_q  <= rol_in;
            amt_q   <= rol_val;
            stage_q <= '0;
            state_q <= StShift;
            idle_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StShift: begin
          if (amt_q[stage_q]) begin
            data_q <= rot;
          end
          stage_q <= stage_q + 1'b1;
          if (stage_q == LastStage) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              data_q  <= rol_in;
              amt_q   <= rol_val;
              stage_q <= '0;
              state_q <= StShift;
            end else begin
              state_q <= StIdle;
              idle_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          idle_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rol_iter.sv
// Self-checking bench for rol_iter: directed corner cases plus randomized operands
// compared against a rotate-right based reference.
module tb_rol_iter;

  logic        clk;
  logic        rst_n;
  logic [15:0] rol_in;
  logic [3:0]  rol_val;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] rol_out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  rol_iter #(
    .WIDTH(16),
    .AMT_W(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rol_in   (rol_in),
    .rol_val  (rol_val),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rol_out  (rol_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Rotate-left by k expressed as rotate-right by (16-k) mod 16.
  function automatic logic [15:0] ref_rol(input logic [15:0] x, input int k);
    logic [31:0] w;
    int r;
    r = (16 - k) & 15;
    w = {x, x} >> r;
    return w[15:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] x, input logic [3:0] k);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    rol_in   = x;
    rol_val  = k;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    rol_in   = 16'hDEAD;
    rol_val  = 4'hF;
  endtask

  // Count edges from the accept edge until out_valid rises.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] x, input logic [3:0] k,
                        input logic [15:0] exp);
    int lat;
    send(x, k);
    wait_valid(lat);
    check({tag, "_lat"}, lat, 32'd4);
    check(tag, {16'd0, rol_out}, {16'd0, exp});
    handshake();
    check({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [15:0] x, nx;
    logic [3:0]  k, nk;
    bit b2b;
    int stall;

    rst_n     = 1'b0;
    rol_in    = '0;
    rol_val   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_rol_out", {16'd0, rol_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    #5 rst_n = 1'b1;
    step();
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    run_op("basic_1", 16'h8001, 4'd1, 16'h0003);
    run_op("basic_4", 16'h1234, 4'd4, 16'h2341);
    run_op("amt_0", 16'hABCD, 4'd0, 16'hABCD);
    run_op("amt_15", 16'h0001, 4'd15, 16'h8000);
    run_op("amt_8", 16'hF00F, 4'd8, 16'h0FF0);

    // Back-pressure: result held, extra operand ignored.
    send(16'h00FF, 4'd3);
    wait_valid(lat);
    check("bp_lat", lat, 32'd4);
    rol_in   = 16'h1111;
    rol_val  = 4'd5;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data", {16'd0, rol_out}, 32'h07F8);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    in_valid = 1'b0;
    handshake();
    check("bp_idle_valid", {31'd0, out_valid}, 32'd0);
    check("bp_idle_busy", {31'd0, busy}, 32'd0);
    check("bp_idle_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back: new operand accepted in the same cycle as the result handshake.
    send(16'h8001, 4'd1);
    wait_valid(lat);
    check("b2b_first", {16'd0, rol_out}, 32'h0003);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    rol_in    = 16'h4000;
    rol_val   = 4'd2;
    #1;
    check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_valid(lat);
    check("b2b_lat", lat, 32'd4);
    check("b2b_second", {16'd0, rol_out}, 32'h0001);
    handshake();

    // Asynchronous reset two cycles into SHIFT.
    send(16'hFFFF, 4'd7);
    step();
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", {16'd0, rol_out}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    run_op("post_rst_op", 16'h1234, 4'd4, 16'h2341);

    // Random operands with random stalls and random back-to-back handoffs.
    x = 16'($urandom);
    k = 4'($urandom);
    send(x, k);
    for (int i = 0; i < 1000; i++) begin
      wait_valid(lat);
      check("rnd_lat", lat, 32'd4);
      stall = $urandom_range(0, 3);
      repeat (stall) step();
      check("rnd_valid", {31'd0, out_valid}, 32'd1);
      check("rnd_data", {16'd0, rol_out}, {16'd0, ref_rol(x, int'(k))});
      nx  = 16'($urandom);
      nk  = 4'($urandom);
      b2b = ($urandom_range(0, 1) == 1) && (i < 999);
      out_ready = 1'b1;
      if (b2b) begin
        in_valid = 1'b1;
        rol_in   = nx;
        rol_val  = nk;
      end
      step();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      if (!b2b && i < 999) send(nx, nk);
      x = nx;
      k = nk;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
